// File: rtl/fll_cfg_ctrl.sv
// Configuration sequencer for fll_top: request handshake, cfgreq strobe, lock blanking and qualification.
// Optional feature macro FLL_CTRL_RETRY_EN: on timeout, re-issue the request up to MAX_RETRY times.
module fll_cfg_ctrl #(
  parameter int RANGE_W       = 4,
  parameter int CFGREQ_CYCLES = 3,
  parameter int BLANK_CYCLES  = 4,
  parameter int LOCK_STABLE   = 8,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int MAX_RETRY     = 2
) (
  input  logic               fll_ref_clk,
  input  logic               fll_rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [RANGE_W-1:0] cfg_range,
  input  logic               cfg_bypass,
  input  logic               cfg_opmode,
  input  logic               fll_lock,
  output logic               fll_cfgreq,
  output logic [RANGE_W-1:0] fll_range,
  output logic               fll_bypass,
  output logic               fll_opmode,
  output logic               ctrl_busy,
  output logic               ctrl_locked,
  output logic               ctrl_err,
  output logic               ctrl_lock_lost
);

  localparam int PH_MAX = (CFGREQ_CYCLES > BLANK_CYCLES) ? CFGREQ_CYCLES : BLANK_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int ST_W   = $clog2(LOCK_STABLE + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, BLANK, WAIT_LOCK, LOCKED, ERROR} state_t;

  state_t             state, state_nxt;
  logic               sync1, lock_s;
  logic [PH_W-1:0]    phase_cnt, phase_nxt;
  logic [ST_W-1:0]    stable_cnt, stable_nxt, stable_inc;
  logic [TO_W-1:0]    timeout_cnt, timeout_nxt, timeout_inc;
  logic               cfgreq_nxt, bypass_nxt, opmode_nxt, err_nxt, lost_nxt;
  logic [RANGE_W-1:0] range_nxt;
  logic               accept;
`ifdef FLL_CTRL_RETRY_EN
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RT_W-1:0]    retry_cnt, retry_nxt;
`endif

  assign cfg_ready   = (state == IDLE) || (state == LOCKED) || (state == ERROR);
  assign ctrl_busy   = (state == REQ) || (state == BLANK) || (state == WAIT_LOCK);
  assign ctrl_locked = (state == LOCKED);
  assign accept      = cfg_valid && cfg_ready;

  // fll_lock comes from the FLL clock domain; only the synchronized copy is used
  always_ff @(posedge fll_ref_clk or negedge fll_rst_n) begin
    if (!fll_rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= fll_lock;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge fll_ref_clk or negedge fll_rst_n) begin
    if (!fll_rst_n) begin
      state          <= IDLE;
      phase_cnt      <= '0;
      stable_cnt     <= '0;
      timeout_cnt    <= '0;
      fll_cfgreq     <= 1'b0;
      fll_range      <= '0;
      fll_bypass     <= 1'b0;
      fll_opmode     <= 1'b1;
      ctrl_err       <= 1'b0;
      ctrl_lock_lost <= 1'b0;
`ifdef FLL_CTRL_RETRY_EN
      retry_cnt      <= '0;
`endif
    end else begin
      state          <= state_nxt;
      phase_cnt      <= phase_nxt;
      stable_cnt     <= stable_nxt;
      timeout_cnt    <= timeout_nxt;
      fll_cfgreq     <= cfgreq_nxt;
      fll_range      <= range_nxt;
      fll_bypass     <= bypass_nxt;
      fll_opmode     <= opmode_nxt;
      ctrl_err       <= err_nxt;
      ctrl_lock_lost <= lost_nxt;
`ifdef FLL_CTRL_RETRY_EN
      retry_cnt      <= retry_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase_cnt;
    stable_nxt  = stable_cnt;
    timeout_nxt = timeout_cnt;
    cfgreq_nxt  = fll_cfgreq;
    range_nxt   = fll_range;
    bypass_nxt  = fll_bypass;
    opmode_nxt  = fll_opmode;
    err_nxt     = ctrl_err;
    lost_nxt    = ctrl_lock_lost;
`ifdef FLL_CTRL_RETRY_EN
    retry_nxt   = retry_cnt;
`endif
    stable_inc  = lock_s ? (stable_cnt + 1'b1) : '0;
    timeout_inc = (timeout_cnt == TO_W'(LOCK_TIMEOUT)) ? timeout_cnt : (timeout_cnt + 1'b1);

    // A new request always wins, including over a loss of lock in the same cycle
    if (accept) begin
      state_nxt  = REQ;
      phase_nxt  = '0;
      cfgreq_nxt = 1'b1;
      range_nxt  = cfg_range;
      bypass_nxt = cfg_bypass;
      opmode_nxt = cfg_opmode;
      err_nxt    = 1'b0;
      lost_nxt   = 1'b0;
`ifdef FLL_CTRL_RETRY_EN
      retry_nxt  = '0;
`endif
    end else begin
      case (state)
        REQ: begin
          if (phase_cnt == PH_W'(CFGREQ_CYCLES - 1)) begin
            cfgreq_nxt = 1'b0;
            phase_nxt  = '0;
            state_nxt  = fll_bypass ? IDLE : BLANK;
          end else begin
            phase_nxt = phase_cnt + 1'b1;
          end
        end
        BLANK: begin
          if (phase_cnt == PH_W'(BLANK_CYCLES - 1)) begin
            phase_nxt   = '0;
            stable_nxt  = '0;
            timeout_nxt = '0;
            state_nxt   = WAIT_LOCK;
          end else begin
            phase_nxt = phase_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          stable_nxt  = stable_inc;
          timeout_nxt = timeout_inc;
          if (stable_inc == ST_W'(LOCK_STABLE)) begin
            state_nxt = LOCKED;
          end else if (timeout_inc == TO_W'(LOCK_TIMEOUT)) begin
`ifdef FLL_CTRL_RETRY_EN
            if (retry_cnt < RT_W'(MAX_RETRY)) begin
              retry_nxt  = retry_cnt + 1'b1;
              phase_nxt  = '0;
              cfgreq_nxt = 1'b1;
              state_nxt  = REQ;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ERROR;
            end
`else
            err_nxt   = 1'b1;
            state_nxt = ERROR;
`endif
          end
        end
        LOCKED: begin
          if (!lock_s) begin
            lost_nxt    = 1'b1;
            stable_nxt  = '0;
            timeout_nxt = '0;
            state_nxt   = WAIT_LOCK;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Directed self-checking bench for fll_cfg_ctrl; expectations adapt to FLL_CTRL_RETRY_EN.
module tb_fll_cfg_ctrl;

  logic       fll_ref_clk = 1'b0;
  logic       fll_rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_range;
  logic       cfg_bypass;
  logic       cfg_opmode;
  logic       fll_lock;
  logic       fll_cfgreq;
  logic [3:0] fll_range;
  logic       fll_bypass;
  logic       fll_opmode;
  logic       ctrl_busy;
  logic       ctrl_locked;
  logic       ctrl_err;
  logic       ctrl_lock_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  logic prev_req = 1'b0;

  fll_cfg_ctrl dut (
    .fll_ref_clk    (fll_ref_clk),
    .fll_rst_n      (fll_rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_range      (cfg_range),
    .cfg_bypass     (cfg_bypass),
    .cfg_opmode     (cfg_opmode),
    .fll_lock       (fll_lock),
    .fll_cfgreq     (fll_cfgreq),
    .fll_range      (fll_range),
    .fll_bypass     (fll_bypass),
    .fll_opmode     (fll_opmode),
    .ctrl_busy      (ctrl_busy),
    .ctrl_locked    (ctrl_locked),
    .ctrl_err       (ctrl_err),
    .ctrl_lock_lost (ctrl_lock_lost)
  );

  always #5 fll_ref_clk = ~fll_ref_clk;

  // Advance n rising edges, landing 1 time unit after the last one, counting cfgreq pulses
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fll_ref_clk);
      #1;
      if (fll_cfgreq && !prev_req) pulses++;
      prev_req = fll_cfgreq;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    fll_rst_n  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_range  = 4'd0;
    cfg_bypass = 1'b0;
    cfg_opmode = 1'b0;
    fll_lock   = 1'b0;

    // Reset values
    applyStimulus(3);
    checkOutput("rst_cfgreq", 32'(fll_cfgreq), 32'd0);
    checkOutput("rst_range", 32'(fll_range), 32'd0);
    checkOutput("rst_bypass", 32'(fll_bypass), 32'd0);
    checkOutput("rst_opmode", 32'(fll_opmode), 32'd1);
    checkOutput("rst_ready", 32'(cfg_ready), 32'd1);
    checkOutput("rst_busy", 32'(ctrl_busy), 32'd0);
    checkOutput("rst_err", 32'(ctrl_err), 32'd0);
    checkOutput("rst_locked", 32'(ctrl_locked), 32'd0);
    checkOutput("rst_lost", 32'(ctrl_lock_lost), 32'd0);
    fll_rst_n = 1'b1;
    applyStimulus(2);

    // Normal lock: range 7, lock rises 20 cycles after cfgreq falls
    cfg_valid = 1'b1; cfg_range = 4'd7; cfg_opmode = 1'b0;
    applyStimulus(1);
    cfg_valid = 1'b0;
    checkOutput("acc_cfgreq", 32'(fll_cfgreq), 32'd1);
    checkOutput("acc_range", 32'(fll_range), 32'd7);
    checkOutput("acc_opmode", 32'(fll_opmode), 32'd0);
    checkOutput("acc_ready", 32'(cfg_ready), 32'd0);
    checkOutput("acc_busy", 32'(ctrl_busy), 32'd1);
    applyStimulus(2);
    checkOutput("req_hold", 32'(fll_cfgreq), 32'd1);
    applyStimulus(1);
    checkOutput("req_fall", 32'(fll_cfgreq), 32'd0);
    applyStimulus(20);
    fll_lock = 1'b1;
    applyStimulus(9);
    checkOutput("lock_early", 32'(ctrl_locked), 32'd0);
    checkOutput("busy_early", 32'(ctrl_busy), 32'd1);
    applyStimulus(1);
    checkOutput("lock_on", 32'(ctrl_locked), 32'd1);
    checkOutput("lock_busy", 32'(ctrl_busy), 32'd0);
    checkOutput("lock_ready", 32'(cfg_ready), 32'd1);
    checkOutput("lock_err", 32'(ctrl_err), 32'd0);

    // One-cycle loss of lock while locked
    fll_lock = 1'b0;
    applyStimulus(1);
    fll_lock = 1'b1;
    applyStimulus(1);
    checkOutput("loss_sync_lat", 32'(ctrl_locked), 32'd1);
    applyStimulus(1);
    checkOutput("loss_locked", 32'(ctrl_locked), 32'd0);
    checkOutput("loss_flag", 32'(ctrl_lock_lost), 32'd1);
    checkOutput("loss_busy", 32'(ctrl_busy), 32'd1);
    checkOutput("loss_no_req", 32'(fll_cfgreq), 32'd0);
    applyStimulus(7);
    checkOutput("relock_early", 32'(ctrl_locked), 32'd0);
    applyStimulus(1);
    checkOutput("relock", 32'(ctrl_locked), 32'd1);
    checkOutput("lost_sticky", 32'(ctrl_lock_lost), 32'd1);
    cfg_valid = 1'b1; cfg_range = 4'd8;
    applyStimulus(1);
    cfg_valid = 1'b0;
    fll_lock  = 1'b0;
    checkOutput("lost_clear", 32'(ctrl_lock_lost), 32'd0);
    checkOutput("r8_range", 32'(fll_range), 32'd8);
    checkOutput("r8_locked", 32'(ctrl_locked), 32'd0);

    // Lock glitch: high 5, low 1, high again during WAIT_LOCK
    applyStimulus(10);
    fll_lock = 1'b1;
    applyStimulus(5);
    fll_lock = 1'b0;
    applyStimulus(1);
    fll_lock = 1'b1;
    applyStimulus(9);
    checkOutput("glitch_early", 32'(ctrl_locked), 32'd0);
    applyStimulus(1);
    checkOutput("glitch_lock", 32'(ctrl_locked), 32'd1);

    // Bypass request returns to IDLE after the strobe
    cfg_valid = 1'b1; cfg_bypass = 1'b1; cfg_range = 4'd2; cfg_opmode = 1'b1;
    applyStimulus(1);
    cfg_valid = 1'b0;
    checkOutput("byp_bypass", 32'(fll_bypass), 32'd1);
    checkOutput("byp_cfgreq", 32'(fll_cfgreq), 32'd1);
    checkOutput("byp_locked", 32'(ctrl_locked), 32'd0);
    applyStimulus(2);
    checkOutput("byp_hold", 32'(fll_cfgreq), 32'd1);
    applyStimulus(1);
    checkOutput("byp_fall", 32'(fll_cfgreq), 32'd0);
    checkOutput("byp_idle_busy", 32'(ctrl_busy), 32'd0);
    checkOutput("byp_idle_ready", 32'(cfg_ready), 32'd1);
    applyStimulus(20);
    checkOutput("byp_no_err", 32'(ctrl_err), 32'd0);
    checkOutput("byp_no_lock", 32'(ctrl_locked), 32'd0);

    // Lock never arrives: timeout (with optional retries)
    fll_lock = 1'b0;
    cfg_valid = 1'b1; cfg_bypass = 1'b0; cfg_range = 4'd5;
    pulses = 0;
    applyStimulus(1);
    cfg_valid = 1'b0;
`ifdef FLL_CTRL_RETRY_EN
    applyStimulus(4102);
    checkOutput("to1_pre", 32'(fll_cfgreq), 32'd0);
    applyStimulus(1);
    checkOutput("retry1_req", 32'(fll_cfgreq), 32'd1);
    checkOutput("retry1_err", 32'(ctrl_err), 32'd0);
    applyStimulus(8205);
    checkOutput("to3_pre_err", 32'(ctrl_err), 32'd0);
    checkOutput("to3_pre_busy", 32'(ctrl_busy), 32'd1);
    applyStimulus(1);
    checkOutput("pulses", 32'(pulses), 32'd3);
`else
    applyStimulus(4102);
    checkOutput("to_pre_err", 32'(ctrl_err), 32'd0);
    checkOutput("to_pre_busy", 32'(ctrl_busy), 32'd1);
    applyStimulus(1);
    checkOutput("pulses", 32'(pulses), 32'd1);
`endif
    checkOutput("to_err", 32'(ctrl_err), 32'd1);
    checkOutput("to_busy", 32'(ctrl_busy), 32'd0);
    checkOutput("to_ready", 32'(cfg_ready), 32'd1);
    checkOutput("to_cfgreq", 32'(fll_cfgreq), 32'd0);
    checkOutput("to_range", 32'(fll_range), 32'd5);
    applyStimulus(5);
    checkOutput("err_sticky", 32'(ctrl_err), 32'd1);

    // Asynchronous reset in the middle of REQ
    cfg_valid = 1'b1; cfg_range = 4'd9; cfg_opmode = 1'b0;
    applyStimulus(1);
    cfg_valid = 1'b0;
    checkOutput("err_clear", 32'(ctrl_err), 32'd0);
    applyStimulus(1);
    checkOutput("mid_req", 32'(fll_cfgreq), 32'd1);
    #2 fll_rst_n = 1'b0;
    #1;
    checkOutput("arst_cfgreq", 32'(fll_cfgreq), 32'd0);
    checkOutput("arst_range", 32'(fll_range), 32'd0);
    checkOutput("arst_opmode", 32'(fll_opmode), 32'd1);
    checkOutput("arst_ready", 32'(cfg_ready), 32'd1);
    checkOutput("arst_busy", 32'(ctrl_busy), 32'd0);
    checkOutput("arst_err", 32'(ctrl_err), 32'd0);
    applyStimulus(2);
    fll_rst_n = 1'b1;
    applyStimulus(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
